// File: rtl/uart_imem_loader.sv
// UART 8N1 receiver plus boot loader: assembles little-endian words from the serial
// stream and writes them into instruction memory while holding the core in reset.
module uart_imem_loader #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 8
) (
    input  logic              clock_reg,
    input  logic              reset,
    input  logic              rx,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              frame_err,
    output logic              hdr_err,
    output logic [ADDR_W-2:0] words_loaded,
    output logic [1:0]        rx_state,
    output logic [1:0]        ld_state
);

    localparam int          CPB         = CLK_FREQ / BAUD;
    localparam int          HALF        = CPB / 2;
    localparam int          CNT_W       = $clog2(CPB + 1);
    localparam int          WL_W        = ADDR_W - 1;
    localparam logic [31:0] MAX_WORDS   = 32'((2 ** ADDR_W) / 4);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {L_HDR, L_DATA, L_DONE} ld_state_t;

    rx_state_t  rxs;
    ld_state_t  lds;

    logic             rs_meta;
    logic             rs;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             byte_bad;
    logic             wait_high;

    logic [WL_W-1:0]  n_words;
    logic [1:0]       k;
    logic [23:0]      lanes;

    assign rx_state = rxs;
    assign ld_state = lds;

    // Receiver: samples mid-bit using the synchronised line.
    always_ff @(posedge clock_reg) begin
        if (!reset) begin
            rs_meta    <= 1'b1;
            rs         <= 1'b1;
            rxs        <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            byte_bad   <= 1'b0;
            frame_err  <= 1'b0;
            wait_high  <= 1'b0;
        end else begin
            rs_meta    <= rx;
            rs         <= rs_meta;
            byte_valid <= 1'b0;
            byte_bad   <= 1'b0;
            case (rxs)
                R_IDLE: begin
                    // After a bad stop bit the line must return high before a new start counts.
                    if (wait_high) begin
                        if (rs) wait_high <= 1'b0;
                    end else if (!rs) begin
                        rxs     <= R_START;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
                end
                R_START: begin
                    if (cnt == CNT_W'(HALF - 1)) begin
                        cnt <= '0;
                        rxs <= rs ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (cnt == CNT_W'(CPB - 1)) begin
                        cnt     <= '0;
                        shreg   <= {rs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rxs <= R_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                R_STOP: begin
                    if (cnt == CNT_W'(CPB - 1)) begin
                        cnt <= '0;
                        rxs <= R_IDLE;
                        if (rs) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shreg;
                        end else begin
                            byte_bad  <= 1'b1;
                            frame_err <= 1'b1;
                            wait_high <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: rxs <= R_IDLE;
            endcase
        end
    end

    // Loader: header byte gives the word count, then 4 bytes per word, LSB lane first.
    always_ff @(posedge clock_reg) begin
        if (!reset) begin
            lds          <= L_HDR;
            we           <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            hdr_err      <= 1'b0;
            words_loaded <= '0;
            n_words      <= '0;
            k            <= '0;
            lanes        <= '0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            if (byte_bad) begin
                lds <= L_HDR;
                k   <= '0;
            end else begin
                case (lds)
                    L_HDR: begin
                        if (byte_valid) begin
                            if (rx_byte != 8'd0 && {24'd0, rx_byte} <= MAX_WORDS) begin
                                n_words      <= WL_W'(rx_byte);
                                cpu_hold     <= 1'b1;
                                words_loaded <= '0;
                                waddr        <= '0;
                                k            <= '0;
                                lds          <= L_DATA;
                            end else begin
                                hdr_err <= 1'b1;
                            end
                        end
                    end
                    L_DATA: begin
                        if (we) begin
                            // Last word keeps its address so waddr never wraps past the top.
                            words_loaded <= words_loaded + WL_W'(1);
                            if (words_loaded + WL_W'(1) == n_words) lds <= L_DONE;
                            else waddr <= waddr + ADDR_W'(4);
                        end else if (byte_valid) begin
                            case (k)
                                2'd0: lanes[7:0]   <= rx_byte;
                                2'd1: lanes[15:8]  <= rx_byte;
                                2'd2: lanes[23:16] <= rx_byte;
                                default: begin
                                    we    <= 1'b1;
                                    wdata <= {rx_byte, lanes};
                                end
                            endcase
                            k <= k + 2'd1;
                        end
                    end
                    L_DONE: begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        lds      <= L_HDR;
                    end
                    default: lds <= L_HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Randomised bench for uart_imem_loader: a byte-level loader model predicts every
// memory write and completion; a monitor compares them as the DUT emits them.
module tb_uart_imem_loader;

    localparam int CPB       = 16;
    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx = 1'b1;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              cpu_hold;
    logic              done;
    logic              frame_err;
    logic              hdr_err;
    logic [ADDR_W-2:0] words_loaded;
    logic [1:0]        rx_state;
    logic [1:0]        ld_state;

    always #5 clk = ~clk;

    uart_imem_loader #(.CLK_FREQ(1_600_000), .BAUD(100_000), .ADDR_W(ADDR_W)) dut (
        .clock_reg(clk), .reset(reset), .rx(rx), .we(we), .waddr(waddr), .wdata(wdata),
        .cpu_hold(cpu_hold), .done(done), .frame_err(frame_err), .hdr_err(hdr_err),
        .words_loaded(words_loaded), .rx_state(rx_state), .ld_state(ld_state)
    );

    logic [39:0] exp_q[$];
    int          done_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_we_cyc = -100;

    bit          m_loading, m_hold, m_hdr_err, m_frame_err;
    int          m_n, m_cnt, m_k;
    logic [31:0] m_word;

    task automatic check(string name, logic [39:0] act, logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_loading = 0; m_hold = 0; m_hdr_err = 0; m_frame_err = 0;
        m_n = 0; m_cnt = 0; m_k = 0; m_word = '0;
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic model_byte(logic [7:0] b, bit ok);
        if (!ok) begin
            m_frame_err = 1;
            m_loading   = 0;
        end else if (!m_loading) begin
            if (b >= 1 && b <= MAX_WORDS) begin
                m_loading = 1; m_hold = 1; m_n = b; m_cnt = 0; m_k = 0;
            end else begin
                m_hdr_err = 1;
            end
        end else begin
            m_word[8*m_k +: 8] = b;
            m_k++;
            if (m_k == 4) begin
                exp_q.push_back({8'(4 * m_cnt), m_word});
                m_cnt++;
                m_k = 0;
                if (m_cnt == m_n) begin
                    done_q.push_back(m_n);
                    m_loading = 0;
                    m_hold    = 0;
                end
            end
        end
    endtask

    task automatic wait_cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(logic [7:0] b, bit ok = 1);
        model_byte(b, ok);
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        rx = ok;
        wait_cycles(CPB);
        rx = 1'b1;
        if (!ok) wait_cycles(CPB);
        wait_cycles($urandom_range(0, 6));
    endtask

    task automatic send_word(logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic check_idle();
        check("idle_we", we, 0);
        check("idle_waddr", waddr, 0);
        check("idle_wdata", wdata, 0);
        check("idle_cpu_hold", cpu_hold, 0);
        check("idle_done", done, 0);
        check("idle_frame_err", frame_err, 0);
        check("idle_hdr_err", hdr_err, 0);
        check("idle_words_loaded", words_loaded, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx = ~rx;
            @(negedge clk);
        end
        model_reset();
        check_idle();
        rx    = 1'b1;
        reset = 1'b1;
        wait_cycles(4);
    endtask

    task automatic end_check();
        wait_cycles(60);
        check("writes_pending", exp_q.size(), 0);
        check("done_pending", done_q.size(), 0);
        check("frame_err", frame_err, m_frame_err);
        check("hdr_err", hdr_err, m_hdr_err);
        check("cpu_hold", cpu_hold, m_hold);
        check("words_loaded", words_loaded, m_cnt);
    endtask

    // Monitor: every write and every done pulse must match the next predicted one.
    initial begin
        logic [39:0] e;
        int          n;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                if (we) begin
                    if (exp_q.size() == 0) begin
                        check("we_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("waddr", waddr, e[39:32]);
                        check("wdata", wdata, e[31:0]);
                        check("hold_at_we", cpu_hold, 1);
                    end
                    last_we_cyc = cyc;
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        check("done_unexpected", 1, 0);
                    end else begin
                        n = done_q.pop_front();
                        check("words_at_done", words_loaded, n);
                        check("done_latency", cyc - last_we_cyc, 2);
                        check("hold_at_done", cpu_hold, 0);
                    end
                end
            end
        end
    end

    initial begin
        int nw;
        model_reset();

        // T1: reset with rx toggling, then stay idle
        do_reset();
        wait_cycles(30);
        check_idle();

        // T2: single word 0x00100513
        send_byte(8'h01);
        send_byte(8'h13);
        send_byte(8'h05);
        check("hold_mid_load", cpu_hold, 1);
        send_byte(8'h10);
        send_byte(8'h00);
        end_check();

        // T3: full 64-word load, word i = 4*i
        send_byte(8'h40);
        for (int i = 0; i < MAX_WORDS; i++) send_word(32'(4 * i));
        end_check();

        // T4: bad headers, then a normal load
        do_reset();
        send_byte(8'h00);
        send_byte(8'h41);
        end_check();
        send_byte(8'h01);
        send_word($urandom);
        end_check();

        // T5: frame error inside the first word, loader recovers on a new header
        do_reset();
        send_byte(8'h02);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        send_byte(8'($urandom), 0);
        end_check();
        send_byte(8'h01);
        send_word($urandom);
        end_check();

        // Random loads, with an occasional out-of-range header
        do_reset();
        for (int t = 0; t < 3; t++) begin
            if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(MAX_WORDS + 1, 255)));
            nw = $urandom_range(1, 4);
            send_byte(8'(nw));
            for (int i = 0; i < nw; i++) send_word($urandom);
            end_check();
        end

        // T6: short glitch gives no byte; reset in the middle of word 2 aborts cleanly
        do_reset();
        rx = 1'b0;
        wait_cycles(3);
        rx = 1'b1;
        wait_cycles(40);
        send_byte(8'h03);
        send_word($urandom);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        rx = 1'b0;
        wait_cycles(40);
        check("hold_before_abort", cpu_hold, 1);
        do_reset();
        wait_cycles(200);
        check_idle();
        check("writes_pending_abort", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
